// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Y86 fetch stage: PC register, instruction split/decode, next-PC prediction.
// Optional backward-taken/forward-not-taken prediction for conditional jumps: FETCH_BTFN_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter logic [3:0]  BUBBLE_ICODE = 4'h1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [47:0] imem_data,
  input  logic        imem_rdy,
  input  logic        stall,
  input  logic        mispredict,
  input  logic [31:0] redirect_pc,
  input  logic        ret_valid,
  input  logic [31:0] ret_addr,
  output logic [3:0]  f_icode,
  output logic [3:0]  f_ifun,
  output logic [3:0]  f_rA,
  output logic [3:0]  f_rB,
  output logic [31:0] f_valC,
  output logic [31:0] f_valP,
  output logic        f_pred,
  output logic        f_valid,
  output logic        f_err
);

  typedef enum logic [1:0] {S_RUN, S_RET_WAIT, S_HALTED} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;

  logic [3:0]  d_icode, d_ifun, d_ra, d_rb;
  logic [31:0] d_valc, d_valp, pred_pc;
  logic [2:0]  d_len;
  logic        cond_jmp, taken_cond, d_pred;

  logic [3:0]  n_icode, n_ifun, n_ra, n_rb;
  logic [31:0] n_valc, n_valp;
  logic        n_pred, n_valid, n_err, bubble;

  assign imem_addr = pc;

  always_comb begin
    d_icode = imem_data[7:4];
    d_ifun  = imem_data[3:0];
    d_ra    = 4'hF;
    d_rb    = 4'hF;
    d_valc  = 32'h0;
    d_len   = 3'd1;
    case (d_icode)
      4'h2, 4'h6, 4'hA, 4'hB: begin
        d_len = 3'd2;
        d_ra  = imem_data[15:12];
        d_rb  = imem_data[11:8];
      end
      4'h3, 4'h4, 4'h5: begin
        d_len  = 3'd6;
        d_ra   = imem_data[15:12];
        d_rb   = imem_data[11:8];
        d_valc = imem_data[47:16];
      end
      4'h7, 4'h8: begin
        d_len  = 3'd5;
        d_valc = imem_data[39:8];
      end
      default: d_len = 3'd1;
    endcase
    d_valp   = pc + {29'd0, d_len};
    cond_jmp = (d_icode == 4'h7) && (d_ifun != 4'h0);
`ifdef FETCH_BTFN_EN
    taken_cond = d_valc < pc;
`else
    taken_cond = 1'b1;
`endif
    d_pred = cond_jmp && taken_cond;
    case (d_icode)
      4'h7:    pred_pc = (cond_jmp && !taken_cond) ? d_valp : d_valc;
      4'h8:    pred_pc = d_valc;
      4'h9:    pred_pc = pc;
      default: pred_pc = d_valp;
    endcase
  end

  // Defaults hold everything; only the taken branch of the priority chain changes state.
  always_comb begin
    pc_n    = pc;
    state_n = state;
    n_icode = f_icode;
    n_ifun  = f_ifun;
    n_ra    = f_rA;
    n_rb    = f_rB;
    n_valc  = f_valC;
    n_valp  = f_valP;
    n_pred  = f_pred;
    n_valid = f_valid;
    n_err   = f_err;
    bubble  = 1'b0;
    if (mispredict) begin
      pc_n    = redirect_pc;
      state_n = S_RUN;
      bubble  = 1'b1;
    end else if (stall) begin
      if (state == S_RET_WAIT && ret_valid) begin
        pc_n    = ret_addr;
        state_n = S_RUN;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (imem_rdy) begin
            n_icode = d_icode;
            n_ifun  = d_ifun;
            n_ra    = d_ra;
            n_rb    = d_rb;
            n_valc  = d_valc;
            n_valp  = d_valp;
            n_pred  = d_pred;
            n_valid = 1'b1;
            pc_n    = pred_pc;
            if (d_icode == 4'h9) state_n = S_RET_WAIT;
            else if (d_icode == 4'h0) state_n = S_HALTED;
            else if (d_icode > 4'hB) begin
              n_err   = 1'b1;
              state_n = S_HALTED;
            end
          end else begin
            bubble = 1'b1;
          end
        end
        S_RET_WAIT: begin
          bubble = 1'b1;
          if (ret_valid) begin
            pc_n    = ret_addr;
            state_n = S_RUN;
          end
        end
        default: begin
          bubble  = 1'b1;
          state_n = S_HALTED;
        end
      endcase
    end
    if (bubble) begin
      n_icode = BUBBLE_ICODE;
      n_ifun  = 4'h0;
      n_ra    = 4'hF;
      n_rb    = 4'hF;
      n_valc  = 32'h0;
      n_valp  = 32'h0;
      n_pred  = 1'b0;
      n_valid = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc      <= RESET_PC;
      state   <= S_RUN;
      f_icode <= BUBBLE_ICODE;
      f_ifun  <= 4'h0;
      f_rA    <= 4'hF;
      f_rB    <= 4'hF;
      f_valC  <= 32'h0;
      f_valP  <= 32'h0;
      f_pred  <= 1'b0;
      f_valid <= 1'b0;
      f_err   <= 1'b0;
    end else begin
      pc      <= pc_n;
      state   <= state_n;
      f_icode <= n_icode;
      f_ifun  <= n_ifun;
      f_rA    <= n_ra;
      f_rB    <= n_rb;
      f_valC  <= n_valc;
      f_valP  <= n_valp;
      f_pred  <= n_pred;
      f_valid <= n_valid;
      f_err   <= n_err;
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Y86 fetch stage, directly upstream of the decode pipeline register; produces icode/ifun/rA/rB/valC/valP/pred for it.
- Owns the PC register, splits and decodes the 6-byte instruction window, and predicts the next PC.
- Handles load-use stall hold, branch-mispredict redirect, ret wait and halt.
- Outputs are registered on posedge clock; the decode register latches them on the following negedge.

Parameters:
- RESET_PC, 32'h0, PC value loaded on reset.
- BUBBLE_ICODE, 4'h1, icode emitted for bubbles (nop).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- imem_addr  out  32  fetch address, equals current PC
- imem_data  in  48  bytes PC..PC+5; byte0 in [7:0], little-endian
- imem_rdy  in  1  imem_data valid this cycle
- stall  in  1  load-use hazard hold, from hazard detector
- mispredict  in  1  conditional jump resolved not-taken in execute
- redirect_pc  in  32  correct PC when mispredict=1
- ret_valid  in  1  return address available from memory stage
- ret_addr  in  32  return address (valM)
- f_icode, f_ifun, f_rA, f_rB  out  4 each  decoded fields
- f_valC  out  32  constant word
- f_valP  out  32  PC + instruction length
- f_pred  out  1  conditional jump predicted taken
- f_valid  out  1  outputs carry a real instruction (0 = bubble)
- f_err  out  1  invalid icode fetched (sticky until reset)

Behaviour:
- Reset (synchronous, active-high): PC=RESET_PC, state=RUN, f_icode=BUBBLE_ICODE, f_ifun=0, f_rA=f_rB=4'hF, f_valC=0, f_valP=0, f_pred=0, f_valid=0, f_err=0.
  - Reset overrides every other input in the same cycle.
- Decode:
  - icode=byte0[7:4], ifun=byte0[3:0].
  - Length by icode:
    - 1 byte: 0, 1, 9.
    - 2 bytes: 2, 6, A, B; rA=byte1[7:4], rB=byte1[3:0].
    - 6 bytes: 3, 4, 5; regs from byte1, valC=bytes2..5.
    - 5 bytes: 7, 8; valC=bytes1..4; rA=rB=F.
  - Unused rA/rB = 4'hF; unused valC = 0.
  - valP = PC + len, modulo 2^32 (wraps silently).
- Next-PC prediction:
  - icode 7 or 8 -> valC.
  - icode 9 -> hold PC.
  - All other icodes -> valP.
  - f_pred=1 for icode 7 with ifun!=0; otherwise 0.
- State machine: RUN, RET_WAIT, HALTED.
- Priority each posedge: reset > mispredict > stall > state action.
- mispredict=1, any state:
  - PC<=redirect_pc, state<=RUN, emit bubble.
  - Squashes a wrong-path ret/halt; f_err is not cleared.
- stall=1, no mispredict:
  - PC, state and all f_* outputs hold.
  - Exception: in RET_WAIT with ret_valid=1, PC<=ret_addr and state<=RUN; outputs still hold.
- RUN, imem_rdy=0: emit bubble, PC holds.
- RUN, imem_rdy=1: register the decoded fields with f_valid=1, PC<=predicted PC. Then:
  - icode 9: state<=RET_WAIT.
  - icode 0: state<=HALTED.
  - icode>B: f_err<=1, state<=HALTED.
- RET_WAIT: emit bubbles; on ret_valid, PC<=ret_addr, state<=RUN, with fetch resuming next cycle. ret_valid is ignored in RUN and HALTED.
- HALTED: emit bubbles, PC holds, imem ignored; exits only on mispredict or reset.
- "Emit bubble" means f_icode=BUBBLE_ICODE, f_ifun=0, f_rA=f_rB=F, f_valC=0, f_valP=0, f_pred=0, f_valid=0.

Optional Feature:
- FETCH_BTFN_EN defined:
  - Conditional jXX (ifun!=0) is predicted taken only if valC < PC (unsigned); otherwise next PC=valP and f_pred=0.
  - Unconditional jmp and call are always taken.
- Undefined: all conditional jumps are predicted taken (f_pred=1, next PC=valC).

Test Plan:
- Reset, then imem_data for irmovl 0x12345678,%ebx at PC 0 (30 F3 78 56 34 12) -> f_icode=3, f_rA=F, f_rB=3, f_valC=32'h12345678, f_valP=6, f_valid=1; PC becomes 6.
- jne 0x40 at PC 0x10 -> f_pred=1, PC=0x40. Next cycle mispredict=1 with redirect_pc=0x15 -> bubble, PC=0x15.
- ret at PC 0x20 -> f_icode=9, then 3 bubbles. ret_valid=1 with ret_addr=0x88 -> PC=0x88 and fetch resumes at 0x88.
- stall=1 for 2 cycles after addl at PC 8 -> outputs hold at f_icode=6 and PC holds 0x0A; on release, fetch continues from 0x0A.
- Byte0=0xC0 -> f_err=1, HALTED, bubbles. Then mispredict with redirect_pc=0x30 -> RUN at 0x30 with f_err still 1. reset mid-RET_WAIT -> PC=RESET_PC, state RUN.
- With FETCH_BTFN_EN defined: jl 0x80 at PC 0x100 -> f_pred=1, PC=0x80. jl 0x200 at PC 0x100 -> f_pred=0, PC=0x105.
